// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: WIDTH iterations, start/ready handshake, signed overflow flag.
// Optional macro MULT_HI_WORD_EN adds the result_hi port (upper WIDTH bits of the product).
module booth_mult_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] result,
`ifdef MULT_HI_WORD_EN
    output logic [WIDTH-1:0] result_hi,
`endif
    output logic             result_rdy,
    output logic             exception,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH:0]   r_m;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_rdy;
    logic             r_exc;
`ifdef MULT_HI_WORD_EN
    logic [WIDTH-1:0] r_hi;
`endif

    logic             w_sub;
    logic             w_add_en;
    logic             w_last;
    logic             w_exc;
    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_sum;
    logic [NSLICE:0]  w_carry;
    logic [WIDTH:0]   w_a_upd;
    logic [WIDTH:0]   w_a_sh;
    logic [WIDTH-1:0] w_q_sh;

    // Booth pair {Q[0],q_m1}: 10 subtracts (~M + 1), 01 adds, 00/11 hold.
    assign w_sub    = r_q[0] & ~r_qm1;
    assign w_add_en = r_q[0] ^ r_qm1;
    assign w_addend = w_sub ? ~r_m : r_m;
    assign w_carry[0] = w_sub;

    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        assign {w_carry[g+1], w_sum[g*8 +: 8]} =
            {1'b0, r_a[g*8 +: 8]} + {1'b0, w_addend[g*8 +: 8]} + {8'b0, w_carry[g]};
    end

    assign w_sum[WIDTH] = r_a[WIDTH] ^ w_addend[WIDTH] ^ w_carry[NSLICE];

    assign w_a_upd = w_add_en ? w_sum : r_a;
    assign w_a_sh  = {w_a_upd[WIDTH], w_a_upd[WIDTH:1]};
    assign w_q_sh  = {w_a_upd[0], r_q[WIDTH-1:1]};
    assign w_last  = (r_cnt == LAST_CNT);
    // Product fits only if every bit of A is a copy of the result's sign bit.
    assign w_exc   = (w_a_sh != {(WIDTH+1){w_q_sh[WIDTH-1]}});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (w_last) w_state_nxt = S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_m      <= '0;
            r_a      <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_rdy    <= 1'b0;
            r_exc    <= 1'b0;
`ifdef MULT_HI_WORD_EN
            r_hi     <= '0;
`endif
        end else if (start) begin
            r_a   <= '0;
            r_q   <= multiplier;
            r_qm1 <= 1'b0;
            r_m   <= {multiplicand[WIDTH-1], multiplicand};
            r_cnt <= '0;
            r_rdy <= 1'b0;
            r_exc <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (r_state == S_RUN) begin
                r_a   <= w_a_sh;
                r_q   <= w_q_sh;
                r_qm1 <= r_q[0];
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_result <= w_q_sh;
                    r_exc    <= w_exc;
                    r_rdy    <= 1'b1;
`ifdef MULT_HI_WORD_EN
                    r_hi     <= w_a_sh[WIDTH-1:0];
`endif
                end
            end
        end
    end

    assign result     = r_result;
    assign result_rdy = r_rdy;
    assign exception  = r_exc;
    assign busy       = (r_state == S_RUN);
`ifdef MULT_HI_WORD_EN
    assign result_hi  = r_hi;
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: latency, signed products, overflow, abort, async reset, idle stability.
// Checks result_hi as well when MULT_HI_WORD_EN is defined.
module tb_booth_mult_seq;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] result;
    logic        result_rdy;
    logic        exception;
    logic        busy;
`ifdef MULT_HI_WORD_EN
    logic [31:0] result_hi;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    booth_mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .result      (result),
`ifdef MULT_HI_WORD_EN
        .result_hi   (result_hi),
`endif
        .result_rdy  (result_rdy),
        .exception   (exception),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, result, 32'h0);
        check({tag, "_rdy"}, 32'(result_rdy), 32'h0);
        check({tag, "_exc"}, 32'(exception), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
`ifdef MULT_HI_WORD_EN
        check({tag, "_hi"}, result_hi, 32'h0);
`endif
    endtask

    // Pulse start, scramble operands while iterating, expect result_rdy exactly in cycle 33.
    task automatic run_mult(input string tag, input logic [31:0] m, input logic [31:0] q,
                            input logic [31:0] exp_r, input logic exp_e, input logic [31:0] exp_hi);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        step();
        start = 1'b0;
        cyc   = 1;
        while (!result_rdy && cyc < 45) begin
            check({tag, "_busy_run"}, 32'(busy), 32'h1);
            multiplicand = $urandom;
            multiplier   = $urandom;
            step();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd33);
        check({tag, "_rdy"}, 32'(result_rdy), 32'h1);
        check({tag, "_busy_done"}, 32'(busy), 32'h0);
        check({tag, "_result"}, result, exp_r);
        check({tag, "_exc"}, 32'(exception), 32'(exp_e));
`ifdef MULT_HI_WORD_EN
        check({tag, "_hi"}, result_hi, exp_hi);
`else
        if (exp_hi === 32'hx) $display("unused hi expectation");
`endif
        step();
        check({tag, "_rdy_drop"}, 32'(result_rdy), 32'h0);
        repeat (6) step();
        check({tag, "_held"}, result, exp_r);
        check({tag, "_exc_held"}, 32'(exception), 32'(exp_e));
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        step();
        step();
        check_all_zero("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            multiplicand = $urandom;
            multiplier   = $urandom;
            step();
            check_all_zero("idle");
        end

        run_mult("m3q5",   32'd3,          32'd5,          32'd15,         1'b0, 32'h0);
        run_mult("mn7q6",  32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6,   1'b0, 32'hFFFFFFFF);
        run_mult("maxx2",  32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE,   1'b1, 32'h0);
        run_mult("minxn1", 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1, 32'h0);
        run_mult("minsq",  32'h80000000,   32'h80000000,   32'h0,          1'b1, 32'h40000000);
        run_mult("n1n1",   32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0, 32'h0);
        run_mult("zero",   32'h0,          32'h12345678,   32'h0,          1'b0, 32'h0);

        // Abort: restart in cycle 10, old operation must never complete.
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        start        = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            check("abort_early_rdy", 32'(result_rdy), 32'h0);
            step();
        end
        multiplicand = 32'd4;
        multiplier   = 32'd4;
        start        = 1'b1;
        step();
        start = 1'b0;
        cyc   = 11;
        while (!result_rdy && cyc < 60) begin
            check("abort_busy", 32'(busy), 32'h1);
            step();
            cyc++;
        end
        check("abort_latency", 32'(cyc), 32'd43);
        check("abort_result", result, 32'd16);
        check("abort_exc", 32'(exception), 32'h0);
        step();

        // Async reset in cycle 15 of a running multiply.
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        start        = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        step();
        step();
        check_all_zero("rst_hold");
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            check("rst_after_rdy", 32'(result_rdy), 32'h0);
            check("rst_after_busy", 32'(busy), 32'h0);
        end
        check("rst_after_result", result, 32'h0);

        run_mult("m9q9", 32'd9, 32'd9, 32'd81, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequential radix-2 Booth multiplier for the ALU's MULT opcode; sits directly downstream of the 8-bit adder slices.
- Consumes their sums once per cycle: WIDTH/8 cascaded 8-bit adder slices form the accumulator adder, plus one sign-extension full-adder bit.
- Returns the low WIDTH bits of the signed product with an overflow flag, through a start/ready handshake to the CPU's multdiv stall logic.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 8 (adder slices instantiated WIDTH/8 times).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; loads operands and begins a multiply.
- multiplicand  input  WIDTH  signed operand M, sampled only on start.
- multiplier  input  WIDTH  signed operand Q, sampled only on start.
- result  output  WIDTH  low WIDTH bits of the signed product.
- result_rdy  output  1  one-cycle pulse; result/exception valid.
- exception  output  1  product does not fit in WIDTH signed bits.
- busy  output  1  high while iterating.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; result=0, result_rdy=0, exception=0, busy=0, counter=0, accumulator=0.
- Datapath: M register (WIDTH+1, sign-extended); accumulator A (WIDTH+1); Q register (WIDTH); q_m1 bit.
- Adder: low WIDTH bits from the cascaded slices, carry rippled slice to slice; bit WIDTH from one full-adder bit on the sign extensions.
- Subtraction: ~M with carry-in 1.
- States: IDLE, RUN, DONE.
- start sampled high in any state (including RUN): A=0, Q=multiplier, q_m1=0, M=sext(multiplicand), counter=0, state=RUN, busy=1, result_rdy=0, exception=0. Start during RUN aborts the old operation; no result_rdy for it.
- RUN, each edge:
  - {Q[0],q_m1}=01: A=A+M.
  - {Q[0],q_m1}=10: A=A-M.
  - 00/11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_m1} by 1; counter++.
- On the edge where counter reaches WIDTH-1 (the WIDTH-th iteration):
  - State goes to DONE; busy=0; result_rdy=1.
  - result = Q after the shift.
  - exception = 1 unless the upper WIDTH+1 bits of the 2*WIDTH+1-bit product {A,Q} all equal the result MSB.
- Latency: start high in cycle 0 → result_rdy high in cycle WIDTH+1 (33 for the default), exactly one cycle.
- DONE: result_rdy returns to 0 next cycle; result/exception held until the next start. IDLE is entered only from reset.
- Boundaries:
  - Operand changes outside a start pulse have no effect.
  - M = -2^(WIDTH-1) is handled by the WIDTH+1-bit accumulator (no internal overflow).
  - Zero operands still take the full WIDTH cycles.
  - reset_n asserted mid-RUN clears everything immediately; no result_rdy.
  - result and exception change only on the completion edge (and reset).

Optional Feature:
- Macro: MULT_HI_WORD_EN.
- Defined: adds output port result_hi (WIDTH bits), the upper WIDTH bits of the 2*WIDTH product, i.e. {A[WIDTH-1:0]} after the final shift. result_hi is updated/held/reset with identical timing to result (reset value 0).
- Undefined: port absent; A's upper bits are used only for the exception compare. All other behaviour is identical.

Test Plan:
- Reset then start with M=3, Q=5 (cycle 0) → busy 1 in cycles 1-32; result_rdy=1 only in cycle 33; result=15, exception=0; result still 15 in cycle 40.
- M=-7 (0xFFFFFFF9), Q=6 → result=0xFFFFFFD6 (-42), exception=0; with MULT_HI_WORD_EN, result_hi=0xFFFFFFFF.
- M=0x7FFFFFFF, Q=2 → result=0xFFFFFFFE, exception=1; M=0x80000000, Q=0xFFFFFFFF → result=0x80000000, exception=1, result_hi=0x00000000.
- Start M=3, Q=5; re-pulse start in cycle 10 with M=4, Q=4 → no result_rdy at cycle 33; result_rdy in cycle 43 with result=16.
- Start M=9, Q=9; drop reset_n in cycle 15 for 2 cycles → all outputs 0 immediately and stay 0 with no result_rdy. Then start M=9, Q=9 → result=81 after 33 cycles.
- Hold start low and toggle operands randomly for 100 cycles after reset → result_rdy, busy, result, exception remain 0.
